alarm_ctrl: RTL

Alarm sequencer for the digital clock: consumes the running time (seconds/minutes/hours/day) and the alarm-set registers produced by the timekeeping top level, and drives the buzzer. It replaces the purely combinational time/alarm compare with a stateful controller that fires once per matching minute, auto-silences after a fixed ring time, supports an "every day" alarm, and optionally provides snooze. Clocked by the 1 Hz pulse, so one cycle is one second.

---
 rtl/alarm_ctrl_pkg.sv | 22 ++
 rtl/alarm_ctrl_if.sv | 28 ++
 rtl/alarm_ctrl_match.sv | 22 ++
 rtl/alarm_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alarm_ctrl_pkg.sv
// Shared types and defaults for the alarm sequencer and its time/alarm comparator.
package alarm_pkg;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      ARMED  = 2'd1,
      RING   = 2'd2,
      SNOOZE = 2'd3
   } alarm_state_e;

   localparam int unsigned TW     = 7;
   localparam int unsigned DEF_NS = 60;
   localparam int unsigned DEF_NH = 24;
   localparam int unsigned DEF_ND = 7;
   localparam int unsigned ANYDAY = DEF_ND;

   // Alarm day code meaning "every day" for a given day modulus.
   function automatic int unsigned anyday(input int unsigned nd);
      return nd;
   endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Time/alarm inputs and buzzer outputs of the alarm sequencer, grouped as one bundle.
interface alarm_ctrl_if;
   import alarm_pkg::*;

   logic          alarmon;
   logic          snooze;
   logic [TW-1:0] tsec;
   logic [TW-1:0] tmin;
   logic [TW-1:0] thrs;
   logic [TW-1:0] tdays;
   logic [TW-1:0] amin;
   logic [TW-1:0] ahrs;
   logic [TW-1:0] adays;
   logic          buzz;
   logic          snoozing;
   logic [1:0]    state;

   modport master (
      output alarmon, snooze, tsec, tmin, thrs, tdays, amin, ahrs, adays,
      input  buzz, snoozing, state
   );

   modport slave (
      input  alarmon, snooze, tsec, tmin, thrs, tdays, amin, ahrs, adays,
      output buzz, snoozing, state
   );

endinterface

// File: rtl/alarm_ctrl_match.sv
// Combinational time/alarm comparator; true only on second 0 of the matching minute.
module alarm_match
   import alarm_pkg::*;
#(
   parameter int unsigned ND = DEF_ND
) (
   input  logic [TW-1:0] i_tsec,
   input  logic [TW-1:0] i_tmin,
   input  logic [TW-1:0] i_thrs,
   input  logic [TW-1:0] i_tdays,
   input  logic [TW-1:0] i_amin,
   input  logic [TW-1:0] i_ahrs,
   input  logic [TW-1:0] i_adays,
   output logic          o_match
);

   logic w_day_ok;

   assign w_day_ok = (i_adays == TW'(anyday(ND))) || (i_tdays == i_adays);
   assign o_match  = (i_tsec == '0) && (i_tmin == i_amin) && (i_thrs == i_ahrs) && w_day_ok;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: fires once per matching minute, auto-silences after RING_SEC cycles.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int unsigned NS         = DEF_NS,
   parameter int unsigned NH         = DEF_NH,
   parameter int unsigned ND         = DEF_ND,
   parameter int unsigned RING_SEC   = 60,
   parameter int unsigned SNOOZE_MIN = 9
) (
   input  logic        clk,
   input  logic        rst,
   alarm_ctrl_if.slave bus
);

   localparam int unsigned RW          = $clog2(RING_SEC);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
   localparam int unsigned l_unused_cfg = NS + NH + SNOOZE_MIN;

   alarm_state_e  r_state;
   alarm_state_e  w_next;
   logic [RW-1:0] r_ring_ct;
   logic [RW-1:0] w_ring_nx;
   logic          r_buzz;
   logic          w_match;

   alarm_match #(.ND(ND)) u_match (
      .i_tsec  (bus.tsec),
      .i_tmin  (bus.tmin),
      .i_thrs  (bus.thrs),
      .i_tdays (bus.tdays),
      .i_amin  (bus.amin),
      .i_ahrs  (bus.ahrs),
      .i_adays (bus.adays),
      .o_match (w_match)
   );

`ifdef ALARM_SNOOZE_EN
   localparam int unsigned SW         = $clog2(SNOOZE_MIN * NS);
   localparam logic [SW-1:0] SNZ_LOAD = SW'(SNOOZE_MIN * NS - 1);

   logic [SW-1:0] r_snz_ct;
   logic [SW-1:0] w_snz_nx;
   logic          r_snooze_q;
   logic          r_snoozing;
   logic          w_snooze_rise;

   assign w_snooze_rise = bus.snooze && !r_snooze_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_snz_ct   <= '0;
         r_snooze_q <= 1'b0;
         r_snoozing <= 1'b0;
      end else begin
         r_snz_ct   <= w_snz_nx;
         r_snooze_q <= bus.snooze;
         r_snoozing <= (w_next == SNOOZE);
      end
   end

   assign bus.snoozing = r_snoozing;
`else
   logic w_unused_snooze;
   assign w_unused_snooze = bus.snooze;
   assign bus.snoozing    = 1'b0;
`endif

   always_comb begin
      w_next    = r_state;
      w_ring_nx = r_ring_ct;
`ifdef ALARM_SNOOZE_EN
      w_snz_nx  = r_snz_ct;
`endif
      if (!bus.alarmon) begin
         w_next    = OFF;
         w_ring_nx = '0;
`ifdef ALARM_SNOOZE_EN
         w_snz_nx  = '0;
`endif
      end else begin
         case (r_state)
            OFF:   w_next = ARMED;
            ARMED: begin
               if (w_match) begin
                  w_next    = RING;
                  w_ring_nx = '0;
               end
            end
            RING: begin
               w_ring_nx = r_ring_ct + 1'b1;
               // A fresh snooze press outranks the timeout on the final ring cycle.
`ifdef ALARM_SNOOZE_EN
               if (w_snooze_rise) begin
                  w_next    = SNOOZE;
                  w_snz_nx  = SNZ_LOAD;
                  w_ring_nx = '0;
               end else
`endif
               if (r_ring_ct == RING_LAST) begin
                  w_next    = ARMED;
                  w_ring_nx = '0;
               end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
               if (r_snz_ct == '0) begin
                  w_next    = RING;
                  w_ring_nx = '0;
               end else begin
                  w_snz_nx = r_snz_ct - 1'b1;
               end
            end
`endif
            default: w_next = OFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= OFF;
         r_ring_ct <= '0;
         r_buzz    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_ring_ct <= w_ring_nx;
         r_buzz    <= (w_next == RING);
      end
   end

   assign bus.buzz  = r_buzz;
   assign bus.state = r_state;

endmodule
